pin_code_programmer: RTL and testbench
======================================

// Module: pin_code_programmer
// PURPOSE
//   Writer side of the stored unlock code. Accepts a new PIN as DIGITS key-entered
//   BCD digits, requires an identical second entry for confirmation, then commits it
//   to the pinCode register that feeds the code-checking state machine.
//   Sits between the button/keypad decode logic and the pin checker. Enabled only
//   while the lock is unlocked.
// PARAMETERS
//   DIGITS          4                 number of BCD digits in the unlock code
//   CODE_LENGTH     4*DIGITS          bits of stored code (4 per digit)
//   DEFAULT_CODE    16'h0000          pinCode value after reset (CODE_LENGTH wide)
//   TIMEOUT_CYCLES  50_000_000        idle cycles between digits before abort (>=2)
// PORTS
//   clock        in   1            system clock, all logic on rising edge
//   reset        in   1            asynchronous, active-high; clears all state
//   unlocked     in   1            lock currently open; program requests gated by it
//   program      in   1            1-cycle pulse: start programming a new code
//   cancel       in   1            1-cycle pulse: abort entry, keep old code
//   digitValid   in   1            1-cycle pulse: digit is a new key press
//   digit        in   4            BCD digit value, sampled when digitValid=1
//   pinCode      out  CODE_LENGTH  committed code, digit 0 (first entered) in MS nibble
//   busy         out  1            1 while in ENTRY1 or ENTRY2
//   codeUpdated  out  1            1-cycle pulse: new code committed
//   error        out  1            1-cycle pulse: mismatch, bad digit, timeout or cancel
// BEHAVIOUR
//   Reset values: pinCode=DEFAULT_CODE, busy=0, codeUpdated=0, error=0, state=IDLE,
//     entry registers, digit counter and timeout counter all 0.
//   States: IDLE, ENTRY1, ENTRY2, COMMIT, FAIL (all outputs registered).
//   IDLE: program=1 and unlocked=1 -> ENTRY1, clear firstEntry/digit count/timer.
//     program with unlocked=0 ignored. digitValid ignored.
//   ENTRY1: digitValid with digit<=9 -> firstEntry <= {firstEntry[CODE_LENGTH-5:0],digit},
//     count+1, timer cleared. On the DIGITS-th digit -> ENTRY2, count cleared.
//   ENTRY2: identical shift into secondEntry. On DIGITS-th digit: compare
//     {secondEntry shifted with this digit} to firstEntry: equal -> COMMIT, else -> FAIL.
//   COMMIT (1 cycle): pinCode <= firstEntry, codeUpdated=1 -> IDLE.
//     codeUpdated asserts exactly 1 cycle after the clock edge sampling the last digit.
//   FAIL (1 cycle): error=1, pinCode unchanged -> IDLE.
//   Error causes from ENTRY1/ENTRY2, each -> FAIL:
//     digit>9 with digitValid; cancel; timer reaching TIMEOUT_CYCLES-1 with no digit.
//   Timer counts every cycle in ENTRY1/ENTRY2, cleared on each accepted digit and on
//     entering ENTRY1/ENTRY2; width clog2(TIMEOUT_CYCLES).
//   Simultaneous events priority (ENTRY states): cancel > timeout > digitValid.
//   program while busy is ignored (does not restart entry).
//   unlocked dropping mid-entry -> FAIL (old code retained).
//   Entry registers are CODE_LENGTH wide, shifted left by 4; no wrap beyond DIGITS
//     because the count transition consumes exactly DIGITS digits.
//   busy=1 exactly in ENTRY1/ENTRY2; codeUpdated and error never asserted together.
//   Reset mid-entry: partial entry discarded, pinCode returns to DEFAULT_CODE.
// TESTING
//   reset; unlocked=1, program, digits 1,2,3,4 then 1,2,3,4 -> codeUpdated 1 cycle,
//     pinCode=16'h1234, busy=0 after.
//   After above: program, 5,6,7,8 then 5,6,7,9 -> error 1 cycle, pinCode stays 16'h1234.
//   unlocked=0, program, digits 9,9,9,9,9,9,9,9 -> busy stays 0, no pulses, pinCode unchanged.
//   program, digits 1,2 then digit 4'hA -> error, IDLE; then cancel+digitValid same cycle
//     in a fresh entry -> error (cancel wins), no digit stored.
//   TIMEOUT_CYCLES=8: program, digit 3, idle 8 cycles -> error pulse, busy=0.
//   program, 4 digits, assert reset in ENTRY2 -> all outputs at reset values,
//     pinCode=DEFAULT_CODE; normal programming succeeds afterwards.

Source files
------------

// File: rtl/pin_code_programmer.sv
// PIN code programmer: the new code is keyed in twice and committed only if both entries match.
// The committed code feeds the pin checker. All outputs are registered.
module pin_code_programmer #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned CODE_LENGTH = 4 * DIGITS,
  parameter logic [CODE_LENGTH-1:0] DEFAULT_CODE = '0,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   unlocked,
  input  logic                   prog,
  input  logic                   cancel,
  input  logic                   digitValid,
  input  logic [3:0]             digit,
  output logic [CODE_LENGTH-1:0] pinCode,
  output logic                   busy,
  output logic                   codeUpdated,
  output logic                   error
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned CountW = $clog2(DIGITS + 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [CountW-1:0] LastDigit = CountW'(DIGITS - 1);

  typedef enum logic [2:0] {StIdle, StEntry1, StEntry2, StCommit, StFail} state_e;

  state_e                 state_q, state_d;
  logic [CODE_LENGTH-1:0] first_q, first_d;
  logic [CODE_LENGTH-1:0] second_q, second_d;
  logic [CODE_LENGTH-1:0] pin_q, pin_d;
  logic [CountW-1:0]      count_q, count_d;
  logic [TimerW-1:0]      timer_q, timer_d;
  logic                   busy_q, busy_d;
  logic                   upd_q, upd_d;
  logic                   err_q, err_d;

  logic                   digit_ok;
  logic [CODE_LENGTH-1:0] first_shift;
  logic [CODE_LENGTH-1:0] second_shift;

  assign digit_ok     = (digit <= 4'd9);
  assign first_shift  = {first_q[CODE_LENGTH-5:0], digit};
  assign second_shift = {second_q[CODE_LENGTH-5:0], digit};

  // Next-state logic: priority inside the entry states is cancel/lock > timeout > digit.
  always_comb begin
    state_d  = state_q;
    first_d  = first_q;
    second_d = second_q;
    pin_d    = pin_q;
    count_d  = count_q;
    timer_d  = timer_q;

    unique case (state_q)
      StIdle: begin
        if (prog && unlocked) begin
          state_d = StEntry1;
          first_d = '0;
          count_d = '0;
          timer_d = '0;
        end
      end
      StEntry1, StEntry2: begin
        timer_d = timer_q + 1'b1;
        if (cancel || !unlocked) begin
          state_d = StFail;
        end else if (timer_q == TimerMax) begin
          state_d = StFail;
        end else if (digitValid) begin
          if (!digit_ok) begin
            state_d = StFail;
          end else begin
            timer_d = '0;
            count_d = count_q + 1'b1;
            if (state_q == StEntry1) begin
              first_d = first_shift;
              if (count_q == LastDigit) begin
                state_d  = StEntry2;
                count_d  = '0;
                second_d = '0;
              end
            end else begin
              second_d = second_shift;
              if (count_q == LastDigit) begin
                count_d = '0;
                state_d = (second_shift == first_q) ? StCommit : StFail;
              end
            end
          end
        end
      end
      StCommit: begin
        pin_d   = first_q;
        state_d = StIdle;
      end
      StFail: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered status outputs track the state being entered.
  always_comb begin
    busy_d = (state_d == StEntry1) || (state_d == StEntry2);
    upd_d  = (state_d == StCommit);
    err_d  = (state_d == StFail);
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      first_q  <= '0;
      second_q <= '0;
      pin_q    <= DEFAULT_CODE;
      count_q  <= '0;
      timer_q  <= '0;
      busy_q   <= 1'b0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      second_q <= second_d;
      pin_q    <= pin_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      busy_q   <= busy_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
    end
  end

  assign pinCode     = pin_q;
  assign busy        = busy_q;
  assign codeUpdated = upd_q;
  assign error       = err_q;

endmodule

// File: tb/tb_pin_code_programmer.sv
// Testbench for pin_code_programmer: directed stimulus with a scoreboard of expected pulses.
module tb_pin_code_programmer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        unlocked = 1'b0;
  logic        prog = 1'b0;
  logic        cancel = 1'b0;
  logic        digitValid = 1'b0;
  logic [3:0]  digit = 4'd0;
  logic [15:0] pinCode;
  logic        busy;
  logic        codeUpdated;
  logic        error;

  int checks = 0;
  int fails = 0;

  typedef struct packed {
    logic        upd;
    logic [15:0] code;
  } exp_t;
  exp_t exp_q[$];

  pin_code_programmer #(
    .DIGITS(4),
    .CODE_LENGTH(16),
    .DEFAULT_CODE(16'h0000),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .unlocked(unlocked),
    .prog(prog),
    .cancel(cancel),
    .digitValid(digitValid),
    .digit(digit),
    .pinCode(pinCode),
    .busy(busy),
    .codeUpdated(codeUpdated),
    .error(error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic pulse_prog();
    @(negedge clock);
    prog = 1'b1;
    @(negedge clock);
    prog = 1'b0;
  endtask

  task automatic send_digit(input logic [3:0] d);
    @(negedge clock);
    digitValid = 1'b1;
    digit = d;
    @(negedge clock);
    digitValid = 1'b0;
  endtask

  task automatic send_code(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) send_digit(code[i*4 +: 4]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: every pulse must match the oldest expectation; pinCode checked the cycle after.
  always @(negedge clock) begin
    if (!reset && (codeUpdated || error)) begin
      exp_t e;
      check("pulse_exclusive", {31'd0, codeUpdated & error}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_pulse: got upd=%0b err=%0b required none", codeUpdated, error);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {31'd0, codeUpdated}, {31'd0, e.upd});
        @(negedge clock);
        check("pulse_width", {30'd0, codeUpdated, error}, 32'd0);
        check("pin_after_pulse", {16'd0, pinCode}, {16'd0, e.code});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    idle(2);
    check("reset_pin", {16'd0, pinCode}, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_upd", {31'd0, codeUpdated}, 32'd0);
    check("reset_err", {31'd0, error}, 32'd0);
    reset = 1'b0;
    unlocked = 1'b1;
    idle(2);

    // Successful programming of 1234
    pulse_prog();
    check("busy_after_prog", {31'd0, busy}, 32'd1);
    send_code(16'h1234);
    exp_q.push_back('{upd: 1'b1, code: 16'h1234});
    send_code(16'h1234);
    idle(4);
    check("busy_after_commit", {31'd0, busy}, 32'd0);
    check("pin_1234", {16'd0, pinCode}, 32'h1234);

    // Mismatching confirmation keeps the old code
    pulse_prog();
    send_code(16'h5678);
    exp_q.push_back('{upd: 1'b0, code: 16'h1234});
    send_code(16'h5679);
    idle(4);

    // Locked: program ignored, digits ignored
    unlocked = 1'b0;
    pulse_prog();
    check("locked_busy", {31'd0, busy}, 32'd0);
    send_code(16'h9999);
    send_code(16'h9999);
    idle(4);
    check("locked_busy_end", {31'd0, busy}, 32'd0);
    check("locked_pin", {16'd0, pinCode}, 32'h1234);
    unlocked = 1'b1;

    // Lock closing mid-entry aborts
    pulse_prog();
    send_digit(4'd7);
    exp_q.push_back('{upd: 1'b0, code: 16'h1234});
    @(negedge clock);
    unlocked = 1'b0;
    idle(4);
    unlocked = 1'b1;
    idle(2);

    // Invalid BCD digit aborts
    pulse_prog();
    send_digit(4'd1);
    send_digit(4'd2);
    exp_q.push_back('{upd: 1'b0, code: 16'h1234});
    send_digit(4'hA);
    idle(4);
    check("bad_digit_busy", {31'd0, busy}, 32'd0);

    // Cancel beats a simultaneous digit
    pulse_prog();
    exp_q.push_back('{upd: 1'b0, code: 16'h1234});
    @(negedge clock);
    cancel = 1'b1;
    digitValid = 1'b1;
    digit = 4'd5;
    @(negedge clock);
    cancel = 1'b0;
    digitValid = 1'b0;
    idle(4);

    // Fresh programming still works afterwards
    pulse_prog();
    send_code(16'h4321);
    exp_q.push_back('{upd: 1'b1, code: 16'h4321});
    send_code(16'h4321);
    idle(4);

    // Program while busy does not restart the entry
    pulse_prog();
    send_digit(4'd5);
    send_digit(4'd6);
    pulse_prog();
    send_digit(4'd7);
    send_digit(4'd8);
    exp_q.push_back('{upd: 1'b1, code: 16'h5678});
    send_code(16'h5678);
    idle(4);

    // Timeout between digits
    pulse_prog();
    exp_q.push_back('{upd: 1'b0, code: 16'h5678});
    send_digit(4'd3);
    idle(12);
    check("timeout_busy", {31'd0, busy}, 32'd0);

    // Reset in the second entry restores defaults
    pulse_prog();
    send_code(16'h1111);
    send_digit(4'd1);
    send_digit(4'd1);
    check("entry2_busy", {31'd0, busy}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("midreset_pin", {16'd0, pinCode}, 32'h0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_pulses", {30'd0, codeUpdated, error}, 32'd0);
    idle(2);
    reset = 1'b0;
    idle(2);
    pulse_prog();
    send_code(16'h2580);
    exp_q.push_back('{upd: 1'b1, code: 16'h2580});
    send_code(16'h2580);

    // All expected pulses must have been seen
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
    idle(3);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("final_pin", {16'd0, pinCode}, 32'h2580);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
